pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the enable and flush/bubble controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC.
- Resolves load-use hazards, taken-branch squashes and variable-latency data-memory waits.
- Flags a memory timeout error.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Brief    : Shared state encoding and register constants for pipeline control
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use comparator between the ID and EX stages
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       load_use
);

  // $zero never carries a real dependency, so a load targeting it is harmless.
  assign load_use = ex_memread & (ex_rd != REG_ZERO) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush controller for the 5-stage pipeline with memory waits
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_memread,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_wb_bubble,
  output logic                   mem_error,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [7:0]             r_tcnt;
  logic [7:0]             w_tcnt_next;
  logic [STALL_CNT_W-1:0] r_stall;
  logic                   r_err;
  logic                   w_load_use;
  logic                   w_mem_stall;
  logic                   w_freeze;
  logic                   w_decode;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .load_use   (w_load_use)
  );

  assign w_mem_stall = mem_req & ~mem_ready;

  always_comb begin
    w_next_state = r_state;
    w_tcnt_next  = r_tcnt;
    w_freeze     = 1'b0;
    w_decode     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_freeze     = 1'b1;
          w_next_state = MEM_WAIT;
          w_tcnt_next  = 8'd1;
        end else begin
          w_decode = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_decode     = 1'b1;
          w_next_state = RUN;
        end else begin
          w_freeze    = 1'b1;
          w_tcnt_next = r_tcnt + 8'd1;
          if (r_tcnt == c_timeout) begin
            w_next_state = ERROR;
          end
        end
      end
      default: begin
        // ERROR and the unused encoding both hold the pipeline until reset.
        w_freeze = 1'b1;
      end
    endcase
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (w_freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (w_decode) begin
      // A taken branch squashes the dependent instruction, so it wins over load-use.
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_tcnt  <= 8'd0;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tcnt  <= w_tcnt_next;
      if (!pc_en && (r_stall != {STALL_CNT_W{1'b1}})) begin
        r_stall <= r_stall + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_next_state == ERROR) begin
        r_err <= 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign stall_count = r_stall;
  assign mem_error   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed plus randomized check of pipeline_hazard_ctrl vs a model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int W  = 3;
  localparam int SAT = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [4:0]   id_rs, id_rt, ex_rd;
  logic         id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic         pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic         mem_wb_bubble, mem_error;
  logic [1:0]   state;
  logic [W-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(W)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_bubble(mem_wb_bubble), .mem_error(mem_error), .state(state),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=running, 1=waiting on memory, 2=error; m_wait = waiting cycles seen.
  bit m_valid = 0;
  int m_mode, m_wait, m_stalls, n_mode, n_wait, n_stalls;
  bit m_err, n_err;

  always @(negedge clock) begin
    if (m_valid) begin
      bit lu, frz, e_pc, e_ifen, e_iffl, e_idfl, e_bub;
      lu  = ex_memread && ex_rd != 0 &&
            (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
      frz = (m_mode == 2) || (m_mode == 0 && mem_req && !mem_ready) ||
            (m_mode == 1 && !mem_ready);
      e_pc = 1; e_ifen = 1; e_iffl = 0; e_idfl = 0; e_bub = 0;
      n_mode = m_mode; n_wait = m_wait; n_err = m_err;
      if (frz) begin
        e_pc = 0; e_ifen = 0; e_bub = 1;
        if (m_mode == 0) begin
          n_mode = 1; n_wait = 1;
        end else if (m_mode == 1) begin
          if (m_wait == TO) n_mode = 2;
          n_wait = m_wait + 1;
        end
      end else begin
        n_mode = 0;
        if (ex_branch_taken) begin
          e_iffl = 1; e_idfl = 1;
        end else if (lu) begin
          e_pc = 0; e_ifen = 0; e_idfl = 1;
        end
      end
      if (n_mode == 2) n_err = 1;
      n_stalls = e_pc ? m_stalls : ((m_stalls + 1 > SAT) ? SAT : m_stalls + 1);
      check("pc_en", 32'(pc_en), 32'(e_pc));
      check("if_id_en", 32'(if_id_en), 32'(e_ifen));
      check("if_id_flush", 32'(if_id_flush), 32'(e_iffl));
      check("id_ex_en", 32'(id_ex_en), 32'(!frz));
      check("id_ex_flush", 32'(id_ex_flush), 32'(e_idfl));
      check("ex_mem_en", 32'(ex_mem_en), 32'(!frz));
      check("mem_wb_bubble", 32'(mem_wb_bubble), 32'(e_bub));
      check("state", 32'(state), 32'(m_mode));
      check("mem_error", 32'(mem_error), 32'(m_err));
      check("stall_count", 32'(stall_count), 32'(m_stalls));
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_wait = 0; m_stalls = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      m_mode = n_mode; m_wait = n_wait; m_stalls = n_stalls; m_err = n_err;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rd = 0; ex_memread = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    reset = 1; idle();
    step(); step();
    reset = 0;
    // Reset state
    #3; check("pin_reset_state", 32'(state), 0);
    check("pin_reset_cnt", 32'(stall_count), 0);
    check("pin_reset_pc", 32'(pc_en), 1);
    // Load-use on rs
    step(); ex_memread = 1; ex_rd = 5; id_rs = 5;
    #3; check("pin_lu_pc", 32'(pc_en), 0);
    check("pin_lu_flush", 32'(id_ex_flush), 1);
    step(); idle();
    #3; check("pin_lu_after_pc", 32'(pc_en), 1);
    check("pin_lu_cnt", 32'(stall_count), 1);
    // Load to $zero is no hazard
    step(); ex_memread = 1; ex_rd = 0; id_rs = 0;
    #3; check("pin_zero_pc", 32'(pc_en), 1);
    // Branch overrides load-use on rt
    step(); idle(); ex_branch_taken = 1; ex_memread = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1;
    #3; check("pin_br_iffl", 32'(if_id_flush), 1);
    check("pin_br_pc", 32'(pc_en), 1);
    // Three-cycle memory wait then release
    step(); idle(); mem_req = 1;
    step();
    #3; check("pin_mw_state", 32'(state), 1);
    check("pin_mw_bub", 32'(mem_wb_bubble), 1);
    step();
    step(); mem_ready = 1;
    #3; check("pin_mw_rel_pc", 32'(pc_en), 1);
    step(); idle();
    #3; check("pin_mw_after", 32'(state), 0);
    check("pin_mw_cnt", 32'(stall_count), 4);
    // Branch held through a two-cycle wait
    step(); mem_req = 1; ex_branch_taken = 1;
    #3; check("pin_brw_noflush", 32'(if_id_flush), 0);
    step();
    step(); mem_ready = 1;
    #3; check("pin_brw_flush", 32'(id_ex_flush), 1);
    // Timeout into ERROR, with counter saturation along the way
    step(); idle(); mem_req = 1;
    repeat (5) step();
    #3; check("pin_to_state", 32'(state), 2);
    check("pin_to_err", 32'(mem_error), 1);
    check("pin_sat_cnt", 32'(stall_count), SAT);
    step(); mem_ready = 1;
    step();
    #3; check("pin_err_hold", 32'(state), 2);
    step(); reset = 1;
    step(); reset = 0; idle();
    #3; check("pin_rst_state", 32'(state), 0);
    check("pin_rst_err", 32'(mem_error), 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      id_rs           = 5'($urandom_range(0, 7));
      id_rt           = 5'($urandom_range(0, 7));
      ex_rd           = 5'($urandom_range(0, 7));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_memread      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 2) != 0);
      reset           = ($urandom_range(0, 119) == 0);
    end
    step(); reset = 0; idle();
    step();
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
